vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Pixel-timing master for the 640x480 @ 60 Hz display path; runs on vga_clk (25 MHz pixel clock).
- Generates DrawX/DrawY, which feed every sprite mapper. Also generates the hs, vs and blank sync outputs.
- hs, vs and blank pass through a programmable delay line so they stay aligned with mapper RGB, which is valid 2 cycles after DrawX/DrawY (ROM read plus output register).
- Provides a per-frame strobe and a frame counter for sprite-animation frame selection.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, horizontal sync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_DELAY, 2, register stages on hs/vs/blank relative to DrawX/DrawY; legal range 0..4

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- DrawX  out  10  horizontal counter hc, 0..H_TOTAL-1
- DrawY  out  10  vertical counter vc, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active low, delayed SYNC_DELAY
- vs  out  1  vertical sync, active low, delayed SYNC_DELAY
- blank  out  1  1 = active display region (mapper drives RGB), 0 = blanking, delayed SYNC_DELAY
- sync  out  1  constant 0
- frame_start  out  1  one-cycle pulse at frame wrap
- frame_count  out  8  frames elapsed since reset, wraps

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 at defaults).
- Reset (reset_n=0, asynchronous, any cycle including mid-frame):
  - hc=0, vc=0, frame_count=0, frame_start=0.
  - Every delay stage loads the inactive values hs=1, vs=1, blank=0, so outputs show hs=1, vs=1, blank=0 immediately.
  - Release: the first rising edge with reset_n=1 advances hc to 1.
- Counters:
  - hc increments each clock.
  - At hc=H_TOTAL-1, hc wraps to 0 and vc increments.
  - At hc=H_TOTAL-1 and vc=V_TOTAL-1, both wrap to 0.
  - DrawX=hc and DrawY=vc, registered, no added delay.
- Raw sync (combinational from hc/vc):
  - hs_raw=0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs_raw=0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
  - blank_raw=1 iff hc<H_VISIBLE and vc<V_VISIBLE.
- Delay line:
  - hs/vs/blank equal hs_raw/vs_raw/blank_raw delayed by exactly SYNC_DELAY clocks.
  - SYNC_DELAY=0 means combinational pass-through from the counter registers.
  - All stages are reset as above.
- frame_start:
  - Registered; high for exactly the one cycle in which the counters hold (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted on the first cycle after reset release.
  - Undelayed, aligned with DrawX/DrawY.
- frame_count: increments on the same edge that raises frame_start; 255 wraps to 0.
- Period: exactly H_TOTAL*V_TOTAL clocks between consecutive frame_start pulses (420000 at defaults).
- Widths: 10-bit counters hold H_TOTAL-1=799 and V_TOTAL-1=524; parameter sets with totals >1024 are illegal (elaboration assertion).

Test Plan:
- Reset, release, run 2 frames, SYNC_DELAY=0:
  - hs low exactly 96 clocks per line, starting at DrawX=656.
  - vs low for lines 490..491, i.e. 1600 clocks.
  - blank=1 count per frame = 307200.
- Counter wrap:
  - At DrawX=799, DrawY=10 -> next cycle DrawX=0, DrawY=11.
  - At (799,524) -> next cycle (0,0), frame_start=1 for one cycle, frame_count 0->1.
- Delay alignment, SYNC_DELAY=2:
  - blank rises 2 clocks after DrawX=0, DrawY=0.
  - hs falls 2 clocks after DrawX=656.
  - A mapper model's RGB is nonzero only while blank=1.
- Mid-frame reset: assert reset_n=0 at DrawX=300, DrawY=200 -> same cycle hs=1, vs=1, blank=0, DrawX=0, DrawY=0, frame_count=0; after release, no frame_start until 420000 clocks later.
- frame_count wrap: run 256 frames (or preload via force) -> frame_count 255->0 on the 256th frame_start.
- Reset release: first frame_start occurs exactly 420000 clocks after the first active edge, never at release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters, delayed active-low hs/vs and blank, frame strobe and frame counter.
// hs/vs/blank lag DrawX/DrawY by SYNC_DELAY clocks to line up with mapper RGB.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_params
    $error("vga_timing_gen: illegal parameter set");
  end
  logic [10:0] hx, vx;
  logic        h_end, v_end;
  logic [2:0]  raw;
  assign hx    = {1'b0, DrawX};
  assign vx    = {1'b0, DrawY};
  assign h_end = hx == H_LAST;
  assign v_end = vx == V_LAST;
  assign sync  = 1'b0;
  always_comb raw = {!(hx >= HS_START && hx < HS_END), !(vx >= VS_START && vx < VS_END), hx < H_VIS && vx < V_VIS};
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= h_end ? '0 : DrawX + 10'd1;
      DrawY       <= h_end ? (v_end ? '0 : DrawY + 10'd1) : DrawY;
      frame_start <= h_end && v_end;
      frame_count <= frame_count + {7'd0, h_end && v_end};
    end
  // Reset forces the inactive pattern {hs,vs,blank} = 3'b110 even with no delay stages.
  if (SYNC_DELAY == 0) begin : g_nodly
    assign {hs, vs, blank} = reset_n ? raw : 3'b110;
  end else begin : g_dly
    logic [2:0] stage [SYNC_DELAY];
    always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
        for (int i = 0; i < SYNC_DELAY; i++) stage[i] <= 3'b110;
      end else begin
        stage[0] <= raw;
        for (int i = 1; i < SYNC_DELAY; i++) stage[i] <= stage[i-1];
      end
    assign {hs, vs, blank} = stage[SYNC_DELAY-1];
  end
endmodule
